// File: rtl/result_binarizer_ctrl.sv
// Collects NOUT signed fixed-point classifier outputs, thresholds each into one bit of a frame,
// and holds the frame until accepted. Optional argmax index output under RESULT_BINARIZER_ARGMAX_EN.
module result_binarizer_ctrl #(
  parameter int unsigned       DWIDTH = 16,
  parameter int unsigned       FRAC   = 10,
  parameter int unsigned       NOUT   = 10,
  parameter logic [DWIDTH-1:0] THRESH = 16'h0200
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    in_valid,
  input  logic [DWIDTH-1:0]                       in_data,
  output logic                                    in_ready,
  output logic                                    out_valid,
  output logic [NOUT-1:0]                         out_bits,
`ifdef RESULT_BINARIZER_ARGMAX_EN
  output logic [((NOUT > 1) ? $clog2(NOUT) : 1)-1:0] out_idx,
`endif
  input  logic                                    out_ready,
  output logic                                    busy
);

  localparam int unsigned    CW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [CW-1:0]  Last = CW'(NOUT - 1);

  // FRAC only fixes where the binary point sits; the threshold already encodes it.
  if (FRAC >= DWIDTH) begin : g_bad_frac
    $error("FRAC must be smaller than DWIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [NOUT-1:0]  bits_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             above;
  logic             xfer;

  assign above = $signed(in_data) >= $signed(THRESH);
  assign xfer  = in_valid && in_ready_q;

`ifdef RESULT_BINARIZER_ARGMAX_EN
  logic signed [DWIDTH-1:0] max_q;
  logic [CW-1:0]            idx_q;
  logic                     new_max;

  // Strictly greater keeps the lowest index on ties.
  assign new_max = $signed(in_data) > max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= {1'b1, {(DWIDTH-1){1'b0}}};
      idx_q <= '0;
    end else if (state_q == StIdle && start) begin
      max_q <= {1'b1, {(DWIDTH-1){1'b0}}};
      idx_q <= '0;
    end else if (state_q == StCollect && xfer && new_max) begin
      max_q <= $signed(in_data);
      idx_q <= count_q;
    end
  end

  assign out_idx = idx_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      bits_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StCollect;
            count_q    <= '0;
            bits_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StCollect: begin
          if (xfer) begin
            bits_q[count_q] <= above;
            if (count_q == Last) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bits  = bits_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_result_binarizer_ctrl.sv
// Directed self-checking bench for result_binarizer_ctrl (NOUT=10, Q5.10, threshold 0.5).
module tb_result_binarizer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [9:0]  out_bits;
  logic        busy;
`ifdef RESULT_BINARIZER_ARGMAX_EN
  logic [3:0]  out_idx;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] vec_a [10] = '{16'h0200, 16'h01FF, 16'h0400, 16'h0000, 16'hFC00,
                              16'h0200, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001};
  localparam logic [9:0] ExpA = 10'b01_0010_0101;
  logic [15:0] vec_b [10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200};
  localparam logic [9:0] ExpB = 10'b10_0000_0000;
  logic [15:0] vec_c [10] = '{16'h0100, 16'h0000, 16'h0400, 16'h0300, 16'hFFFF,
                              16'h0000, 16'h0000, 16'h0400, 16'h0200, 16'h0001};
  localparam logic [9:0] ExpC = 10'b01_1000_1100;

  result_binarizer_ctrl #(
    .DWIDTH(16),
    .FRAC  (10),
    .NOUT  (10),
    .THRESH(16'h0200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_bits (out_bits),
`ifdef RESULT_BINARIZER_ARGMAX_EN
    .out_idx  (out_idx),
`endif
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_bits} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b bits=%b want all 0",
               in_ready, out_valid, busy, out_bits);
    end
`ifdef RESULT_BINARIZER_ARGMAX_EN
    checks++;
    if (out_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_idx: got %0d want 0", out_idx);
    end
`endif
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_bits !== 10'd0) begin
      failures++;
      $display("FAIL start_enters_collect: got busy=%b rdy=%b bits=%b want 1 1 0",
               busy, in_ready, out_bits);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vec_a[i];
      if (i == 9) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL no_early_valid: got %b want 0", out_valid);
        end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== ExpA || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_frame: got vld=%b bits=%b rdy=%b want 1 %b 0",
               out_valid, out_bits, in_ready, ExpA);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_bits !== ExpA) begin
      failures++;
      $display("FAIL accept_keeps_bits: got vld=%b busy=%b bits=%b want 0 0 %b",
               out_valid, busy, out_bits, ExpA);
    end
  endtask

  task automatic test_gaps();
    do_start();
    checks++;
    if (out_bits !== 10'd0) begin
      failures++;
      $display("FAIL start_clears_bits: got %b want 0", out_bits);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vec_a[i];
      step();
      in_valid = 1'b0;
      in_data  = 16'h7FFF;
      if (i < 9) begin
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL gap_no_transfer[%0d]: got vld=%b rdy=%b want 0 1", i, out_valid,
                   in_ready);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_bits !== ExpA) begin
      failures++;
      $display("FAIL gap_frame: got vld=%b bits=%b want 1 %b", out_valid, out_bits, ExpA);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_data  = 16'h0000;
      start    = ~c[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_bits !== ExpA || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got vld=%b bits=%b rdy=%b busy=%b want 1 %b 0 1",
                 c, out_valid, out_bits, in_ready, busy, ExpA);
      end
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: got vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vec_a[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_bits !== 10'b00_0000_0101) begin
      failures++;
      $display("FAIL partial_bits: got %b want 0000000101", out_bits);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_bits} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b bits=%b want all 0",
               in_ready, out_valid, busy, out_bits);
    end
`ifdef RESULT_BINARIZER_ARGMAX_EN
    checks++;
    if (out_idx !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_idx: got %0d want 0", out_idx);
    end
`endif
    #2;
    reset = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    repeat (3) step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_bits !== 10'd0) begin
      failures++;
      $display("FAIL wait_for_start: got rdy=%b busy=%b bits=%b want 0 0 0",
               in_ready, busy, out_bits);
    end
    do_start();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vec_b[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== ExpB) begin
      failures++;
      $display("FAIL fresh_frame: got vld=%b bits=%b want 1 %b", out_valid, out_bits, ExpB);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

`ifdef RESULT_BINARIZER_ARGMAX_EN
  task automatic test_argmax();
    do_start();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vec_c[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== ExpC || out_idx !== 4'd2) begin
      failures++;
      $display("FAIL argmax_tie: got vld=%b bits=%b idx=%0d want 1 %b 2",
               out_valid, out_bits, out_idx, ExpC);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_hold();
    test_reset_mid_frame();
`ifdef RESULT_BINARIZER_ARGMAX_EN
    test_argmax();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_binarizer_ctrl.md
RESULT_BINARIZER_CTRL -- requirements
Module: result_binarizer_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, the width of one fixed-point classifier output.
REQ-002 The block SHALL have parameter FRAC, default 10, the number of fractional bits in that output.
REQ-003 The block SHALL have parameter NOUT, default 10, the number of classifier outputs per frame.
REQ-004 The block SHALL have parameter THRESH, default 16'h0200 (0.5 in Q5.10), the binarization threshold.
REQ-005 The block SHALL have clk  input  1  as its single clock; all state updates on the rising edge.
REQ-006 The block SHALL have reset  input  1  as an asynchronous, active-high reset.
REQ-007 The block SHALL have start  input  1  to request collection of one frame.
REQ-008 The block SHALL have in_valid  input  1  to mark in_data as valid.
REQ-009 The block SHALL have in_data  input  DWIDTH  carrying one signed classifier output.
REQ-010 The block SHALL have in_ready  output  1  to show it will accept in_data this cycle.
REQ-011 The block SHALL have out_valid  output  1  to mark out_bits as a complete frame.
REQ-012 The block SHALL have out_bits  output  NOUT  holding the binarized frame, bit k = output k.
REQ-013 The block SHALL have out_ready  input  1  for the consumer to accept the frame.
REQ-014 The block SHALL have busy  output  1, high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, COLLECT and HOLD.
REQ-016 In IDLE, start=1 SHALL clear out_bits and the element counter to 0 and move to COLLECT on the next edge.
REQ-017 The block SHALL ignore start in COLLECT and HOLD.
REQ-018 In COLLECT, in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and HOLD.
REQ-019 A transfer SHALL occur only on an edge where in_valid=1 and in_ready=1.
REQ-020 On each transfer, out_bits[count] SHALL be set to 1 when signed(in_data) >= signed(THRESH) and to 0 otherwise, and the counter SHALL increment.
REQ-021 A negative in_data SHALL always produce bit 0.
REQ-022 A transfer with count = NOUT-1 SHALL move the FSM to HOLD, with no wrap of the counter past NOUT-1.
REQ-023 In HOLD, out_valid SHALL be 1 and out_bits SHALL be stable until accepted.
REQ-024 out_ready=1 in HOLD SHALL return the FSM to IDLE on the next edge, dropping out_valid; out_bits SHALL keep their value until the next start.
REQ-025 out_valid SHALL first assert on the edge after the NOUT-th transfer, a latency of 1 cycle.
REQ-026 out_ready SHALL be ignored outside HOLD.
REQ-027 The counter SHALL be clog2(NOUT) bits wide.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, count=0, out_bits=0, in_ready=0, out_valid=0 and busy=0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL discard all partial results; after release, the block SHALL wait for a fresh start.

Configuration
REQ-030 The macro RESULT_BINARIZER_ARGMAX_EN SHALL, when defined, add output out_idx (clog2(NOUT) bits), the index of the largest signed in_data of the frame.
REQ-031 With that macro defined, the running maximum SHALL be cleared on start and updated only on a strictly greater value, so ties resolve to the lowest index.
REQ-032 With that macro defined, out_idx SHALL be valid with out_valid and reset to 0.
REQ-033 Without that macro, the out_idx port and its maximum-tracking logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL check: NOUT=10, start, then ten back-to-back values 0x0200,0x01FF,0x0400,0,0xFC00,0x0200,0,0,0x7FFF,0x0001 -> out_bits=10'b01_0010_0101, out_valid on the edge after the tenth transfer.
REQ-035 The bench SHALL check: in_valid toggling every other cycle with 5-cycle gaps -> same out_bits as the back-to-back case, and no transfer while in_valid=0.
REQ-036 The bench SHALL check: out_ready held 0 for 20 cycles in HOLD -> out_valid and out_bits stable, in_ready=0, extra in_valid pulses and start pulses ignored.
REQ-037 The bench SHALL check: reset pulsed asynchronously after the 4th transfer -> all outputs 0 immediately; a new start and 10 values produce a correct, unpolluted frame.
REQ-038 The bench SHALL check (ARGMAX_EN defined): values with the maximum 0x0400 at indices 2 and 7 -> out_idx=2; with the macro undefined, the build has no out_idx port.
